// File: rtl/sarray_seq.sv
// sarray_seq: tensor load/store sequencer in front of the systolic array.
// Accepts one tensor instruction at a time (PRELOADA, TMMA, STOREC, NOP).
// Loads issue a strided burst of read requests with a bounded number of reads
// in flight and forward each returned beat, tagged with its index, to the
// A buffer or the array top edge. STOREC passes result beats from the array
// bottom straight through to strided write requests. Each instruction
// finishes with a one-cycle done pulse.

package sarray_seq_pkg;

  // Encoding of tinst_type_i.
  typedef enum logic [1:0] {
    TI_PRELOADA = 2'd0,
    TI_TMMA     = 2'd1,
    TI_STOREC   = 2'd2,
    TI_NOP      = 2'd3
  } tinst_e;

  // Sequencer state. A NOP completes from IDLE and needs no state of its own.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_e;

endpackage

module sarray_seq
  import sarray_seq_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 256,
  parameter int BEATS        = 64,
  parameter int STRIDE_SHIFT = 8,
  parameter int MAX_OUTST    = 4,
  parameter int CNT_W        = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,

  // Instruction port
  input  logic              tinst_valid_i,
  output logic              tinst_ready_o,
  input  logic [1:0]        tinst_type_i,
  input  logic [ADDR_W-1:0] tinst_addr_i,
  input  logic              tinst_acc_i,

  // Read request channel
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [ADDR_W-1:0] ar_addr_o,

  // Read data channel
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [DATA_W-1:0] r_data_i,

  // Forwarded load beats
  output logic              ld_valid_o,
  output logic              ld_dst_o,
  output logic [CNT_W-1:0]  ld_idx_o,
  output logic              ld_acc_o,
  output logic [DATA_W-1:0] ld_data_o,

  // Result beats from the array bottom
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [DATA_W-1:0] st_data_i,

  // Write request channel
  output logic              aw_valid_o,
  input  logic              aw_ready_i,
  output logic [ADDR_W-1:0] aw_addr_o,
  output logic [DATA_W-1:0] aw_data_o,

  // Completion
  output logic              done_o
);

  // Outstanding counter must hold MAX_OUTST itself, not just MAX_OUTST-1.
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  localparam logic [CNT_W:0]   BEATS_C = (CNT_W + 1)'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);
  localparam logic [OUT_W-1:0] OUTST_C = OUT_W'(MAX_OUTST);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e              r_state;
  tinst_e              r_type;
  logic [ADDR_W-1:0]   r_base;
  logic                r_acc;

  // One extra bit so the request counter can reach BEATS and stop requesting
  // while the tail of the burst is still in flight.
  logic [CNT_W:0]      r_ar_cnt;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic [OUT_W-1:0]    r_outst;

  logic                r_done;
  logic                r_ld_valid;
  logic                r_ld_dst;
  logic [CNT_W-1:0]    r_ld_idx;
  logic                r_ld_acc;
  logic [DATA_W-1:0]   r_ld_data;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  tinst_e              w_tinst_type;
  logic                w_idle;
  logic                w_in_load;
  logic                w_in_store;
  logic                w_ar_room;
  logic                w_ar_valid;
  logic                w_ar_hs;
  logic                w_r_hs;
  logic                w_aw_hs;
  logic                w_rd_last;
  logic                w_wr_last;
  logic [ADDR_W-1:0]   w_ar_off;
  logic [ADDR_W-1:0]   w_aw_off;
  logic [ADDR_W-1:0]   w_ar_addr;
  logic [ADDR_W-1:0]   w_aw_addr;

  logic                w_aw_valid;
  logic                w_st_ready;
  logic [ADDR_W-1:0]   w_aw_addr_out;
  logic [DATA_W-1:0]   w_aw_data_out;

  assign w_tinst_type = tinst_e'(tinst_type_i);
  assign w_idle       = (r_state == S_IDLE);
  assign w_in_load    = (r_state == S_LOAD);
  assign w_in_store   = (r_state == S_STORE);

  // A request is only offered while beats remain and a read slot is free, so
  // ar_valid_o can only fall without a handshake when the slots run out.
  assign w_ar_room  = (r_ar_cnt < BEATS_C) && (r_outst < OUTST_C);
  assign w_ar_valid = w_in_load && w_ar_room;

  assign w_ar_hs   = w_ar_valid && ar_ready_i;
  assign w_r_hs    = w_in_load && r_valid_i;
  assign w_aw_hs   = w_aw_valid && aw_ready_i;
  assign w_rd_last = (r_rd_cnt == LAST_C);
  assign w_wr_last = (r_wr_cnt == LAST_C);

  // Strided addresses; the sum deliberately wraps modulo 2^ADDR_W.
  assign w_ar_off  = ADDR_W'(r_ar_cnt) << STRIDE_SHIFT;
  assign w_aw_off  = ADDR_W'(r_wr_cnt) << STRIDE_SHIFT;
  assign w_ar_addr = r_base + w_ar_off;
  assign w_aw_addr = r_base + w_aw_off;

  // Zero-latency store pass-through, forced quiet outside STORE.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    w_aw_valid    = 1'b0;
    w_st_ready    = 1'b0;
    w_aw_addr_out = '0;
    w_aw_data_out = '0;
    if (w_in_store) begin
      w_aw_valid    = st_valid_i;
      w_st_ready    = aw_ready_i;
      w_aw_addr_out = w_aw_addr;
      w_aw_data_out = st_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: instruction accept, burst counters, read slots, completion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_type   <= TI_PRELOADA;
      r_base   <= '0;
      r_acc    <= 1'b0;
      r_ar_cnt <= '0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_outst  <= '0;
      r_done   <= 1'b0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples pre-edge values regardless of statement order;
      // a later assignment to the same register in this block takes priority.
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (tinst_valid_i) begin
            r_type <= w_tinst_type;
            r_base <= tinst_addr_i;
            // Only TMMA carries an accumulate flag; a PRELOADA never does.
            r_acc  <= (w_tinst_type == TI_TMMA) && tinst_acc_i;
            case (w_tinst_type)
              TI_PRELOADA: r_state <= S_LOAD;
              TI_TMMA:     r_state <= S_LOAD;
              TI_STOREC:   r_state <= S_STORE;
              TI_NOP:      r_done  <= 1'b1;
              default:     r_state <= S_IDLE;
            endcase
          end
        end

        S_LOAD: begin
          if (w_ar_hs) begin
            r_ar_cnt <= r_ar_cnt + 1'b1;
          end
          // A request and a return in the same cycle cancel out.
          if (w_ar_hs && !w_r_hs) begin
            r_outst <= r_outst + 1'b1;
          end else if (!w_ar_hs && w_r_hs) begin
            r_outst <= r_outst - 1'b1;
          end
          if (w_r_hs) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_rd_last) begin
              r_state  <= S_IDLE;
              r_done   <= 1'b1;
              r_ar_cnt <= '0;
              r_rd_cnt <= '0;
              r_outst  <= '0;
            end
          end
        end

        S_STORE: begin
          if (w_aw_hs) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_wr_last) begin
              r_state  <= S_IDLE;
              r_done   <= 1'b1;
              r_wr_cnt <= '0;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load forwarding register: one cycle from read return to the array side.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_valid <= 1'b0;
      r_ld_dst   <= 1'b0;
      r_ld_idx   <= '0;
      r_ld_acc   <= 1'b0;
      r_ld_data  <= '0;
    end else begin
      r_ld_valid <= w_r_hs;
      if (w_r_hs) begin
        r_ld_data <= r_data_i;
        r_ld_idx  <= r_rd_cnt;
        r_ld_dst  <= (r_type == TI_TMMA);
        r_ld_acc  <= r_acc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tinst_ready_o = w_idle;

  assign ar_valid_o = w_ar_valid;
  assign ar_addr_o  = w_in_load ? w_ar_addr : '0;
  assign r_ready_o  = w_in_load;

  assign ld_valid_o = r_ld_valid;
  assign ld_dst_o   = r_ld_dst;
  assign ld_idx_o   = r_ld_idx;
  assign ld_acc_o   = r_ld_acc;
  assign ld_data_o  = r_ld_data;

  assign st_ready_o = w_st_ready;
  assign aw_valid_o = w_aw_valid;
  assign aw_addr_o  = w_aw_addr_out;
  assign aw_data_o  = w_aw_data_out;

  assign done_o = r_done;

endmodule

// File: tb/tb_sarray_seq.sv
// Self-checking bench for sarray_seq. A driver issues instructions and pushes
// the expected bus requests and load/store beats into queues; a bus responder
// models memory with a configurable read latency; a monitor pops and compares
// whenever the DUT presents a request, a load beat or a done pulse.

module tb_sarray_seq;

  localparam int ADDR_W       = 64;
  localparam int DATA_W       = 256;
  localparam int BEATS        = 64;
  localparam int STRIDE_SHIFT = 8;
  localparam int MAX_OUTST    = 4;
  localparam int CNT_W        = $clog2(BEATS);
  localparam logic [63:0] STRIDE = 64'd1 << STRIDE_SHIFT;

  logic              clk;
  logic              rst_n;
  logic              tinst_valid_i;
  logic              tinst_ready_o;
  logic [1:0]        tinst_type_i;
  logic [ADDR_W-1:0] tinst_addr_i;
  logic              tinst_acc_i;
  logic              ar_valid_o;
  logic              ar_ready_i;
  logic [ADDR_W-1:0] ar_addr_o;
  logic              r_valid_i;
  logic              r_ready_o;
  logic [DATA_W-1:0] r_data_i;
  logic              ld_valid_o;
  logic              ld_dst_o;
  logic [CNT_W-1:0]  ld_idx_o;
  logic              ld_acc_o;
  logic [DATA_W-1:0] ld_data_o;
  logic              st_valid_i;
  logic              st_ready_o;
  logic [DATA_W-1:0] st_data_i;
  logic              aw_valid_o;
  logic              aw_ready_i;
  logic [ADDR_W-1:0] aw_addr_o;
  logic [DATA_W-1:0] aw_data_o;
  logic              done_o;

  sarray_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS),
    .STRIDE_SHIFT(STRIDE_SHIFT), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tinst_valid_i(tinst_valid_i), .tinst_ready_o(tinst_ready_o),
    .tinst_type_i(tinst_type_i), .tinst_addr_i(tinst_addr_i), .tinst_acc_i(tinst_acc_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .ld_valid_o(ld_valid_o), .ld_dst_o(ld_dst_o), .ld_idx_o(ld_idx_o),
    .ld_acc_o(ld_acc_o), .ld_data_o(ld_data_o),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_data_i(st_data_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .aw_data_o(aw_data_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic              dst;
    logic [CNT_W-1:0]  idx;
    logic              acc;
    logic [DATA_W-1:0] data;
  } ld_exp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } aw_exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                rdy;
  } pend_t;

  logic [ADDR_W-1:0] exp_ar[$];
  ld_exp_t           exp_ld[$];
  aw_exp_t           exp_aw[$];
  logic [ADDR_W-1:0] ar_log[$];
  pend_t             pend[$];
  logic [DATA_W-1:0] st_vals[BEATS];

  int n_checks = 0;
  int n_fail   = 0;
  int ar_tot   = 0;
  int ld_tot   = 0;
  int done_cnt = 0;
  int acc_cyc  = 0;

  // Bus responder knobs
  int rd_lat   = 3;
  int r_budget = -1;
  bit ar_rand  = 1'b0;
  bit r_rand   = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents as a pure function of the address.
  function automatic logic [DATA_W-1:0] mem_fn(input logic [63:0] a);
    return {a ^ 64'h5A5A_C3C3_0F0F_9696, ~a, {a[31:0], a[63:32]}, a + 64'h1234_5678_9ABC_DEF0};
  endfunction

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [DATA_W-1:0] v;
    for (int j = 0; j < DATA_W / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus responder: accepts ARs, returns memory data after rd_lat cycles in order.
  // ---------------------------------------------------------------------------
  initial begin
    logic              s_ar_hs;
    logic              s_r_hs;
    logic [ADDR_W-1:0] s_addr;
    ar_ready_i = 1'b0;
    r_valid_i  = 1'b0;
    r_data_i   = '0;
    forever begin
      @(negedge clk);
      s_ar_hs = ar_valid_o && ar_ready_i;
      s_addr  = ar_addr_o;
      s_r_hs  = r_valid_i && r_ready_o;
      @(posedge clk);
      #1;
      if (s_r_hs && pend.size() > 0) begin
        void'(pend.pop_front());
        if (r_budget > 0) r_budget--;
      end
      if (s_ar_hs) pend.push_back('{addr: s_addr, rdy: cyc + rd_lat - 1});
      ar_ready_i = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pend.size() > 0 && r_budget != 0 && cyc >= pend[0].rdy &&
          (!r_rand || $urandom_range(0, 3) != 0)) begin
        r_valid_i = 1'b1;
        r_data_i  = mem_fn(pend[0].addr);
      end else begin
        r_valid_i = 1'b0;
        r_data_i  = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares DUT activity against the expectation queues.
  // ---------------------------------------------------------------------------
  int   tb_outst     = 0;
  int   r_burst      = 0;
  int   w_burst      = 0;
  logic exp_done_nxt = 1'b0;

  always @(negedge clk) begin
    logic    nxt;
    ld_exp_t le;
    aw_exp_t we;
    nxt = 1'b0;
    if (!rst_n) begin
      check("reset_ctrl", {tinst_ready_o, ar_valid_o, r_ready_o, ld_valid_o, done_o,
                           aw_valid_o, st_ready_o}, 7'b1000000);
      check("reset_addr", {ar_addr_o, aw_addr_o, ld_idx_o, ld_dst_o, ld_acc_o}, '0);
      check("reset_ld_data", ld_data_o, '0);
      check("reset_aw_data", aw_data_o, '0);
      exp_ar.delete();
      exp_ld.delete();
      exp_aw.delete();
      tb_outst     = 0;
      r_burst      = 0;
      w_burst      = 0;
      exp_done_nxt = 1'b0;
    end else begin
      check("done_o", done_o, exp_done_nxt);
      if (done_o) done_cnt++;
      if (tinst_ready_o)
        check("idle_no_bus", {ar_valid_o, aw_valid_o, r_ready_o, st_ready_o}, 4'b0000);
      if (ar_valid_o) check("ar_outst_limit", tb_outst < MAX_OUTST, 1'b1);

      if (ld_valid_o) begin
        ld_tot++;
        if (exp_ld.size() == 0) begin
          check("ld_unexpected", 1'b1, 1'b0);
        end else begin
          le = exp_ld.pop_front();
          check("ld_idx", ld_idx_o, le.idx);
          check("ld_dst", ld_dst_o, le.dst);
          check("ld_acc", ld_acc_o, le.acc);
          check("ld_data", ld_data_o, le.data);
        end
      end

      if (ar_valid_o && ar_ready_i) begin
        ar_tot++;
        tb_outst++;
        ar_log.push_back(ar_addr_o);
        if (exp_ar.size() == 0) check("ar_unexpected", 1'b1, 1'b0);
        else check("ar_addr", ar_addr_o, exp_ar.pop_front());
      end

      if (r_valid_i && r_ready_o) begin
        tb_outst--;
        r_burst++;
        if (r_burst == BEATS) begin
          nxt     = 1'b1;
          r_burst = 0;
        end
      end

      if (aw_valid_o && aw_ready_i) begin
        if (exp_aw.size() == 0) begin
          check("aw_unexpected", 1'b1, 1'b0);
        end else begin
          we = exp_aw.pop_front();
          check("aw_addr", aw_addr_o, we.addr);
          check("aw_data", aw_data_o, we.data);
        end
        w_burst++;
        if (w_burst == BEATS) begin
          nxt     = 1'b1;
          w_burst = 0;
        end
      end

      if (tinst_valid_i && tinst_ready_o && tinst_type_i == 2'd3) nxt = 1'b1;
      exp_done_nxt = nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [1:0] t, input logic [63:0] a, input logic acc);
    int n = 0;
    logic [63:0] ba;
    for (int i = 0; i < BEATS; i++) begin
      ba = a + 64'(i) * STRIDE;
      if (t == 2'd0 || t == 2'd1) begin
        exp_ar.push_back(ba);
        exp_ld.push_back('{dst: (t == 2'd1), idx: CNT_W'(i), acc: (t == 2'd1) && acc,
                           data: mem_fn(ba)});
      end else if (t == 2'd2) begin
        exp_aw.push_back('{addr: ba, data: st_vals[i]});
      end
    end
    tinst_valid_i = 1'b1;
    tinst_type_i  = t;
    tinst_addr_i  = a;
    tinst_acc_i   = acc;
    forever begin
      @(negedge clk);
      if (tinst_ready_o) break;
      n++;
      if (n > 3000) begin
        check("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    tinst_valid_i = 1'b0;
    tinst_type_i  = 2'($urandom);
    tinst_addr_i  = {$urandom, $urandom};
    tinst_acc_i   = 1'($urandom);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout", done_cnt >= target, 1'b1);
    #1;
  endtask

  task automatic fill_st_vals();
    for (int i = 0; i < BEATS; i++) st_vals[i] = rand_beat();
  endtask

  task automatic store_run(input bit toggle);
    int k = 0;
    int n = 0;
    while (k < BEATS && n < 4000) begin
      st_valid_i = toggle ? 1'b1 : ($urandom_range(0, 2) != 0);
      aw_ready_i = toggle ? cyc[0] : ($urandom_range(0, 2) != 0);
      st_data_i  = st_vals[k];
      @(negedge clk);
      check("st_ready_mirror", st_ready_o, aw_ready_i);
      check("aw_valid_mirror", aw_valid_o, st_valid_i);
      if (aw_valid_o && aw_ready_i) k++;
      @(posedge clk);
      #1;
      n++;
    end
    check("store_beats", k, BEATS);
    st_valid_i = 1'b0;
    aw_ready_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int s;
    int sa;
    int c1;
    int n;
    logic [1:0]  t;
    logic [63:0] base;

    rst_n         = 1'b0;
    tinst_valid_i = 1'b0;
    tinst_type_i  = 2'd0;
    tinst_addr_i  = '0;
    tinst_acc_i   = 1'b0;
    st_valid_i    = 1'b0;
    st_data_i     = '0;
    aw_ready_i    = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // PRELOADA with a 3-cycle read latency on an always-ready bus.
    rd_lat = 3;
    s  = done_cnt;
    sa = ld_tot;
    issue(2'd0, 64'h1000, 1'b1);
    wait_done(s + 1, 1000);
    check("preload_ld_count", ld_tot - sa, BEATS);
    check("preload_last_ar", ar_log[ar_log.size() - 1], 64'h4F00);
    cycles(2);

    // TMMA with returns held off: request side must stop at the slot limit.
    r_budget = 0;
    sa = ar_tot;
    s  = done_cnt;
    issue(2'd1, 64'h0002_0000, 1'b1);
    cycles(20);
    @(negedge clk);
    #1;
    check("stall_ar_count", ar_tot - sa, MAX_OUTST);
    check("stall_ar_valid", ar_valid_o, 1'b0);
    cycles(1);
    r_budget = 1;
    cycles(8);
    @(negedge clk);
    #1;
    check("one_beat_ar_count", ar_tot - sa, MAX_OUTST + 1);
    check("one_beat_ar_valid", ar_valid_o, 1'b0);
    cycles(1);
    r_budget = -1;
    wait_done(s + 1, 1000);
    cycles(2);

    // STOREC with aw_ready toggling and results always available.
    fill_st_vals();
    s = done_cnt;
    issue(2'd2, 64'h8000, 1'b0);
    store_run(1'b1);
    wait_done(s + 1, 20);
    cycles(2);

    // Address wrap past the top of the address space.
    s  = done_cnt;
    sa = ar_log.size();
    issue(2'd0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);
    wait_done(s + 1, 1000);
    check("wrap_ar0", ar_log[sa], 64'hFFFF_FFFF_FFFF_FF00);
    check("wrap_ar1", ar_log[sa + 1], 64'h0);
    check("wrap_ar2", ar_log[sa + 2], 64'h100);
    cycles(2);

    // NOP immediately followed by PRELOADA.
    s = done_cnt;
    issue(2'd3, 64'h0, 1'b0);
    c1 = acc_cyc;
    issue(2'd0, 64'h0004_0000, 1'b0);
    check("nop_back_to_back", acc_cyc - c1, 1);
    wait_done(s + 2, 1000);
    cycles(2);

    // Reset in the middle of a TMMA, then a fresh PRELOADA.
    rd_lat = 4;
    sa = ld_tot;
    issue(2'd1, 64'h0010_0000, 1'b1);
    n = 0;
    while (ld_tot - sa < 10 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("reset_wait_beats", ld_tot - sa >= 10, 1'b1);
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    @(negedge clk);
    #1;
    check("stale_r_ready", r_ready_o, 1'b0);
    cycles(1);
    pend.delete();
    cycles(2);
    s = done_cnt;
    issue(2'd0, 64'h0020_0000, 1'b0);
    wait_done(s + 1, 1000);
    cycles(2);

    // Randomized instruction mix on a bursty bus.
    ar_rand = 1'b1;
    r_rand  = 1'b1;
    for (int it = 0; it < 8; it++) begin
      t      = 2'($urandom_range(0, 3));
      base   = {$urandom, $urandom};
      rd_lat = $urandom_range(1, 6);
      s      = done_cnt;
      if (t == 2'd2) begin
        fill_st_vals();
        issue(t, base, 1'b0);
        store_run(1'b0);
        wait_done(s + 1, 20);
      end else begin
        issue(t, base, 1'($urandom));
        wait_done(s + 1, 3000);
      end
      cycles($urandom_range(0, 3));
    end

    cycles(5);
    check("exp_ar_drained", exp_ar.size(), 0);
    check("exp_ld_drained", exp_ld.size(), 0);
    check("exp_aw_drained", exp_aw.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete by cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
